// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a circular FIFO of {pc, instr}
// plus predecode flags, with stall backpressure and redirect flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic                     out_is_ctrl,
    output logic                     out_misaligned,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic            ctrl_mem  [DEPTH];
    logic            mis_mem   [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic [6:0]    opcode;
    logic          in_is_ctrl;
    logic          in_misaligned;

    // in_ready looks only at registered occupancy, so a full queue never
    // accepts a push even when decode drains the head in the same cycle.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign opcode        = in_instr[6:0];
    assign in_is_ctrl    = (opcode == 7'b1101111) || (opcode == 7'b1100111) ||
                           (opcode == 7'b1100011);
    assign in_misaligned = (in_pc[1:0] != 2'b00);

    assign out_pc         = pc_mem[rd_ptr];
    assign out_instr      = instr_mem[rd_ptr];
    assign out_is_ctrl    = ctrl_mem[rd_ptr];
    assign out_misaligned = mis_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
                ctrl_mem[i]  <= 1'b0;
                mis_mem[i]   <= 1'b0;
            end
        end else if (flush) begin
            // Entry contents are left in place; only the bookkeeping is cleared.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= in_pc;
                instr_mem[wr_ptr] <= in_instr;
                ctrl_mem[wr_ptr]  <= in_is_ctrl;
                mis_mem[wr_ptr]   <= in_misaligned;
                wr_ptr            <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue (DEPTH=4, XLEN=32), plus
// hand-written reset sequences.
module tb_fetch_queue;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_is_ctrl;
    logic        out_misaligned;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_is_ctrl(out_is_ctrl),
        .out_misaligned(out_misaligned), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each record: inputs applied for one cycle, and the outputs expected in
    // that same cycle (i.e. the state left by the previous edge).
    typedef struct {
        logic        flush;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        int          ecount;
        logic        erdy;
        logic        evalid;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        ectrl;
        logic        emis;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return {pc[24:0], 7'b0010011};
    endfunction

    task automatic add(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] instr, input logic ordy, input int ec,
                       input logic evalid, input logic [31:0] epc,
                       input logic [31:0] einstr, input logic ectrl, input logic emis);
        vec_t v;
        v.flush = fl; v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy;
        v.ecount = ec; v.erdy = (ec != 4); v.evalid = evalid; v.epc = epc;
        v.einstr = einstr; v.ectrl = ectrl; v.emis = emis;
        vq.push_back(v);
    endtask

    // Shorthand for plain aligned non-control traffic.
    task automatic addp(input logic fl, input logic iv, input logic [31:0] pc,
                        input logic ordy, input int ec, input logic evalid,
                        input logic [31:0] epc);
        add(fl, iv, pc, mk(pc), ordy, ec, evalid, epc, mk(epc), 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " count"},     32'(count), 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready"},  32'(in_ready), 32'd1);
        chk({tag, " out_pc"},    out_pc, 32'd0);
        chk({tag, " out_instr"}, out_instr, 32'd0);
        chk({tag, " is_ctrl"},   32'(out_is_ctrl), 32'd0);
        chk({tag, " misalign"},  32'(out_misaligned), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;

        // Fill to full with out_ready low; 5th push (0x10) held off, and still
        // refused in the cycle the first pop happens.
        addp(0,1,32'h00,0, 0,0,0);
        addp(0,1,32'h04,0, 1,1,32'h00);
        addp(0,1,32'h08,0, 2,1,32'h00);
        addp(0,1,32'h0C,0, 3,1,32'h00);
        addp(0,1,32'h10,0, 4,1,32'h00);
        addp(0,1,32'h10,0, 4,1,32'h00);
        addp(0,1,32'h10,1, 4,1,32'h00);
        addp(0,0,32'h0, 1, 3,1,32'h04);
        addp(0,0,32'h0, 1, 2,1,32'h08);
        addp(0,0,32'h0, 1, 1,1,32'h0C);
        addp(0,0,32'h0, 1, 0,0,0);
        // Streaming across the pointer wrap, count holds at 1.
        addp(0,1,32'h100,1, 0,0,0);
        for (int i = 1; i < 10; i++)
            addp(0,1,32'h100 + 32'(4*i),1, 1,1,32'h100 + 32'(4*(i-1)));
        addp(0,0,32'h0,1, 1,1,32'h124);
        addp(0,0,32'h0,1, 0,0,0);
        // Simultaneous push/pop at count 2.
        addp(0,1,32'h300,0, 0,0,0);
        addp(0,1,32'h304,0, 1,1,32'h300);
        addp(0,1,32'h308,1, 2,1,32'h300);
        addp(0,1,32'h30C,1, 2,1,32'h304);
        addp(0,0,32'h0,  1, 2,1,32'h308);
        addp(0,0,32'h0,  1, 1,1,32'h30C);
        addp(0,0,32'h0,  1, 0,0,0);
        // Flush at count 3 with in_valid: 0x40C dropped; 0x200 becomes head.
        addp(0,1,32'h400,0, 0,0,0);
        addp(0,1,32'h404,0, 1,1,32'h400);
        addp(0,1,32'h408,0, 2,1,32'h400);
        addp(1,1,32'h40C,1, 3,1,32'h400);
        addp(0,1,32'h200,0, 0,0,0);
        addp(0,0,32'h0,  1, 1,1,32'h200);
        addp(0,0,32'h0,  1, 0,0,0);
        // Flush while full.
        addp(0,1,32'h500,0, 0,0,0);
        addp(0,1,32'h504,0, 1,1,32'h500);
        addp(0,1,32'h508,0, 2,1,32'h500);
        addp(0,1,32'h50C,0, 3,1,32'h500);
        addp(1,1,32'h510,1, 4,1,32'h500);
        addp(0,0,32'h0,  0, 0,0,0);
        // Flush while empty.
        addp(1,0,32'h0,  1, 0,0,0);
        addp(0,0,32'h0,  0, 0,0,0);
        // Predecode: JAL, misaligned ALU op, JALR, BRANCH, misaligned AUIPC.
        add(0,1,32'h0,32'h0000006F,0, 0,0,0,0,0,0);
        add(0,1,32'h2,32'h00000013,1, 1,1,32'h0,32'h0000006F,1,0);
        add(0,0,32'h0,32'h0,       1, 1,1,32'h2,32'h00000013,0,1);
        add(0,1,32'h4,32'h00008067,0, 0,0,0,0,0,0);
        add(0,1,32'h8,32'h00000063,0, 1,1,32'h4,32'h00008067,1,0);
        add(0,1,32'hB,32'h00000017,1, 2,1,32'h4,32'h00008067,1,0);
        add(0,0,32'h0,32'h0,       1, 2,1,32'h8,32'h00000063,1,0);
        add(0,0,32'h0,32'h0,       0, 1,1,32'hB,32'h00000017,0,1);

        // Reset held for 2 cycles, then released.
        @(negedge clk);
        chk_reset_outputs("rst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_idle");

        foreach (vq[k]) begin
            flush     = vq[k].flush;
            in_valid  = vq[k].iv;
            in_pc     = vq[k].pc;
            in_instr  = vq[k].instr;
            out_ready = vq[k].ordy;
            #1;
            chk($sformatf("v%0d count", k),     32'(count), 32'(vq[k].ecount));
            chk($sformatf("v%0d in_ready", k),  32'(in_ready), 32'(vq[k].erdy));
            chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vq[k].evalid));
            if (vq[k].evalid) begin
                chk($sformatf("v%0d out_pc", k),    out_pc, vq[k].epc);
                chk($sformatf("v%0d out_instr", k), out_instr, vq[k].einstr);
                chk($sformatf("v%0d is_ctrl", k),   32'(out_is_ctrl), 32'(vq[k].ectrl));
                chk($sformatf("v%0d misalign", k),  32'(out_misaligned), 32'(vq[k].emis));
            end
            @(negedge clk);
        end

        // Queue now holds one entry (pc 0xB); async reset must clear it at once.
        chk("pre_rst out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("rst_async");
        @(negedge clk);
        reset_n = 1'b1;
        in_valid = 1'b1; in_pc = 32'h700; in_instr = mk(32'h700);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("post_rst count",  32'(count), 32'd1);
        chk("post_rst out_pc", out_pc, 32'h700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch unit and the decode stage. Each fetched {PC, instruction} pair is captured into a small circular FIFO, along with two predecode flags. Entries are presented in order to decode through a valid/ready handshake. The block provides backpressure to fetch (stall) and discards all buffered instructions on a control-flow redirect (flush).

## Interface
Parameters:
- DEPTH, 4: number of entries; must be a power of two, ≥2
- XLEN, 32: width of PC and instruction

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  redirect (taken branch/jump); discards all entries
- in_valid  in  1  fetch presents an instruction this cycle
- in_ready  out  1  queue can accept; fetch holds PC when low
- in_pc  in  XLEN  PC of fetched instruction
- in_instr  in  XLEN  fetched instruction word
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  XLEN  PC of head entry
- out_instr  out  XLEN  instruction of head entry
- out_is_ctrl  out  1  head opcode[6:0] is 1101111, 1100111 or 1100011
- out_misaligned  out  1  head in_pc[1:0] was nonzero at capture
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of {pc, instr, is_ctrl, misaligned}. Read pointer and write pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. A separate count register holds occupancy.
- Push: occurs when in_valid && in_ready && !flush. The entry at the write pointer is written and the write pointer increments.
- Pop: occurs when out_valid && out_ready && !flush. The read pointer increments.
- Predecode: is_ctrl and misaligned are computed combinationally from in_instr[6:0] and in_pc[1:0] at push time, then stored with the entry.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready. A full queue does not accept a push, even in a cycle where it pops.
- out_valid = (count != 0). out_pc, out_instr and the flags are driven from the entry at the read pointer.
- Count update: push only → count+1; pop only → count−1; push and pop together → count unchanged.
- Flush has the highest priority. On flush, the read pointer, write pointer and count all go to 0, and any same-cycle push and pop are ignored. Entry contents are not cleared.
- No fall-through: a pushed entry is first visible on the outputs in the cycle after the push.
- Inputs must meet these rules:
  - When out_valid is low, out_ready is don't-care.
  - While in_valid && !in_ready, fetch must hold in_pc and in_instr stable.

## Timing
- Reset (reset_n low, asynchronous): pointers = 0, count = 0, all storage = 0. Outputs during reset: out_valid = 0, in_ready = 1, out_pc = 0, out_instr = 0, out_is_ctrl = 0, out_misaligned = 0.
- Reset deassertion takes effect at the first rising edge with reset_n high.
- Reset asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Latency: push at edge N → out_valid high after edge N with that entry at the head (minimum 1 cycle).
- Throughput: one push and one pop per cycle are sustainable when 0 < count < DEPTH.
- Full boundary:
  - count = DEPTH → in_ready low.
  - A pop in that cycle makes in_ready high on the next cycle.
- Empty boundary:
  - count = 0 → out_valid low.
  - A push in that cycle makes out_valid high on the next cycle.
- Pointer wrap: index DEPTH−1 increments to 0. FIFO order must hold across the wrap.
- Flush while full or empty: count = 0 and in_ready = 1 on the next cycle.
- Flush together with in_valid: that instruction is dropped. Fetch redirects its PC in the same cycle.

## Test plan
- Reset then idle: drive reset_n low for 2 cycles, then high → count = 0, out_valid = 0, in_ready = 1, out_pc = 0.
- Fill and drain, DEPTH = 4, out_ready = 0:
  - Push PCs 0x00, 0x04, 0x08, 0x0C → in_ready low at count = 4; a 5th push at PC 0x10 is held off.
  - Then set out_ready = 1 → heads appear in order 0x00, 0x04, 0x08, 0x0C, then out_valid = 0.
- Streaming with wrap: with out_ready = 1 continuously, push 10 sequential PCs starting at 0x100 → outputs match in order with 1-cycle latency, and count stays at 1.
- Simultaneous push/pop at count = 2 → count remains 2 and order is preserved.
- Flush:
  - With count = 3 and in_valid = 1, assert flush → next cycle count = 0, out_valid = 0, and the flushed-cycle instruction never appears.
  - Next push of PC 0x200 is the head one cycle later.
- Predecode:
  - Push instr 0x0000006F (JAL) at PC 0x0 → out_is_ctrl = 1.
  - Push 0x00000013 at PC 0x2 → out_is_ctrl = 0, out_misaligned = 1.
  - Reset asserted mid-stream → outputs return to reset values immediately.
